// File: rtl/soc_timer_slave.sv
// soc_timer_slave: AXI4-Lite slave exposing a 64-bit timer with compare match and a level interrupt.
// Defining SOC_TIMER_PRESCALER_EN adds CTRL.presc and the internal prescale counter.

module soc_timer_slave #(
  parameter logic [63:0] BaseAddr     = 64'h1800_0000,
  parameter logic [63:0] RegionLength = 64'h1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        aw_valid_i,
  output logic        aw_ready_o,
  input  logic [63:0] aw_addr_i,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_strb_i,
  output logic        b_valid_o,
  input  logic        b_ready_i,
  output logic [1:0]  b_resp_o,
  input  logic        ar_valid_i,
  output logic        ar_ready_o,
  input  logic [63:0] ar_addr_i,
  output logic        r_valid_o,
  input  logic        r_ready_i,
  output logic [63:0] r_data_o,
  output logic [1:0]  r_resp_o,
  output logic        irq_o
);

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [11:0] OffMask    = 12'(RegionLength - 64'd1);
`ifdef SOC_TIMER_PRESCALER_EN
  localparam logic [15:0] CtrlMask   = 16'hFF07;
`else
  localparam logic [15:0] CtrlMask   = 16'h0007;
`endif

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  // Word index within the region; only offset bits [11:3] select a register.
  function automatic logic [8:0] word_index(input logic [8:0] addr_hi);
    return (addr_hi - BaseAddr[11:3]) & OffMask[11:3];
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                              input logic [7:0] strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      else         res[8*i +: 8] = old_v[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic is_reg(input logic [8:0] idx);
    return (idx[8:2] == 7'd0);
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_addr_i[63:12], aw_addr_i[2:0], ar_addr_i[63:12], ar_addr_i[2:0]};

  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [8:0]  aw_idx_q, aw_idx_d;
  logic [63:0] w_data_q, w_data_d;
  logic [7:0]  w_strb_q, w_strb_d;
  logic        aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic        b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q, b_resp_d;

  r_state_e    r_state_q, r_state_d;
  logic        ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [63:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;

  logic [63:0] count_q, count_d, compare_q, compare_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic        pending_q, pending_d, irq_q, irq_d;
`ifdef SOC_TIMER_PRESCALER_EN
  logic [7:0]  pcnt_q, pcnt_d;
`endif

  logic        wr_en_s;
  logic [8:0]  wr_idx_s;
  logic [63:0] wr_data_s;
  logic [7:0]  wr_strb_s;
  logic [8:0]  ar_idx_s;
  logic        tick_s, set_s, clr_s;
  logic [63:0] inc_s, ctrl_wr_s;

  // Write channel FSM: collect AW and W in any order, then hold the response.
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    wr_en_s    = 1'b0;
    wr_idx_s   = aw_idx_q;
    wr_data_s  = w_data_q;
    wr_strb_s  = w_strb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_valid_i && aw_ready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = word_index(aw_addr_i[11:3]);
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_valid_i && w_ready_q) begin
          w_held_d = 1'b1;
          w_data_d = w_data_i;
          w_strb_d = w_strb_i;
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) begin
          wr_en_s    = 1'b1;
          wr_idx_s   = aw_idx_d;
          wr_data_s  = w_data_d;
          wr_strb_s  = w_strb_d;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b0;
          b_valid_d  = 1'b1;
          b_resp_d   = is_reg(aw_idx_d) ? RespOkay : RespSlverr;
          w_state_d  = W_RESP;
        end else begin
          aw_ready_d = ~aw_held_d;
          w_ready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          w_state_d  = W_IDLE;
        end else begin
          b_valid_d  = 1'b1;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        aw_ready_d = 1'b1;
        w_ready_d  = 1'b1;
        b_valid_d  = 1'b0;
      end
    endcase
  end

  // Read channel FSM: data is captured from the current register values at the AR handshake.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    ar_idx_s   = word_index(ar_addr_i[11:3]);
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid_i && ar_ready_q) begin
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          r_resp_d   = is_reg(ar_idx_s) ? RespOkay : RespSlverr;
          r_state_d  = R_RESP;
          case (ar_idx_s)
            9'd0:    r_data_d = count_q;
            9'd1:    r_data_d = compare_q;
            9'd2:    r_data_d = {48'd0, ctrl_q};
            9'd3:    r_data_d = {63'd0, pending_q};
            default: r_data_d = 64'd0;
          endcase
        end else begin
          ar_ready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (r_ready_i) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          r_state_d  = R_IDLE;
        end else begin
          r_valid_d  = 1'b1;
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        ar_ready_d = 1'b1;
        r_valid_d  = 1'b0;
      end
    endcase
  end

  // Timer core: counting, compare match and register updates; a bus write to COUNT beats the increment.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    set_s     = 1'b0;
    clr_s     = 1'b0;
    inc_s     = count_q + 64'd1;
    ctrl_wr_s = merge_bytes({48'd0, ctrl_q}, wr_data_s, wr_strb_s);
`ifdef SOC_TIMER_PRESCALER_EN
    tick_s = ctrl_q[0] && (pcnt_q == ctrl_q[15:8]);
    if (ctrl_q[0]) pcnt_d = tick_s ? 8'd0 : pcnt_q + 8'd1;
    else           pcnt_d = pcnt_q;
`else
    tick_s = ctrl_q[0];
`endif
    if (tick_s) begin
      if (inc_s == compare_q) begin
        set_s   = 1'b1;
        count_d = ctrl_q[1] ? 64'd0 : inc_s;
      end else begin
        count_d = inc_s;
      end
    end else begin
      count_d = count_q;
    end
    if (wr_en_s) begin
      case (wr_idx_s)
        9'd0: begin
          count_d = merge_bytes(count_q, wr_data_s, wr_strb_s);
          set_s   = 1'b0;
        end
        9'd1: compare_d = merge_bytes(compare_q, wr_data_s, wr_strb_s);
        9'd2: begin
          ctrl_d = ctrl_wr_s[15:0] & CtrlMask;
`ifdef SOC_TIMER_PRESCALER_EN
          pcnt_d = 8'd0;
`endif
        end
        9'd3:    clr_s = wr_strb_s[0] & wr_data_s[0];
        default: clr_s = 1'b0;
      endcase
    end else begin
      clr_s = 1'b0;
    end
    pending_d = set_s | (pending_q & ~clr_s);
    irq_d     = pending_d & ctrl_d[2];
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= 9'd0;
      w_data_q   <= 64'd0;
      w_strb_q   <= 8'd0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= 64'd0;
      r_resp_q   <= 2'b00;
      count_q    <= 64'd0;
      compare_q  <= 64'd0;
      ctrl_q     <= 16'd0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
`ifdef SOC_TIMER_PRESCALER_EN
      pcnt_q     <= 8'd0;
`endif
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
`ifdef SOC_TIMER_PRESCALER_EN
      pcnt_q     <= pcnt_d;
`endif
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_resp_o   = b_resp_q;
  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign irq_o      = irq_q;

endmodule
